// File: rtl/macc_dot_engine_pkg.sv
// Shared types and constants for the dot-product engine.
// State encoding, default widths and the result clamp limits.
// Imported by the interface, the multiply pipe and the top.
package macc_dot_engine_pkg;

   localparam int MACC_DATA_W = 32;
   localparam int MACC_LEN_W  = 10;
   // Wide enough that 2^LEN_W full-scale products can never wrap internally.
   localparam int MACC_ACC_W  = 2 * MACC_DATA_W + MACC_LEN_W;

   localparam logic [MACC_DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [MACC_DATA_W-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/macc_dot_engine_if.sv
// Handshake bundle between the matrix sequencer and the dot-product engine.
// master = sequencer side (issues start/operands, takes results).
// slave  = engine side.
interface macc_dot_engine_if
   import macc_dot_engine_pkg::*;
#(
   parameter int DATA_W = MACC_DATA_W,
   parameter int LEN_W  = MACC_LEN_W
) ();

   logic              start;
   logic [LEN_W-1:0]  vec_len;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic              sat;

   modport master (
      output start, vec_len, a_in, b_in, in_valid, out_ready,
      input  in_ready, out_data, out_valid, busy, sat
   );

   modport slave (
      input  start, vec_len, a_in, b_in, in_valid, out_ready,
      output in_ready, out_data, out_valid, busy, sat
   );

endinterface

// File: rtl/macc_dot_engine_mul_pipe.sv
// Operand register (S1) followed by a registered signed multiply (S2).
// Latency: 2 cycles from accepted pair to product valid.
// No backpressure: every accepted pair flows through; valids mark bubbles.
module macc_dot_engine_mul_pipe #(
   parameter int DATA_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       in_vld_i,
   input  logic [DATA_W-1:0]          a_i,
   input  logic [DATA_W-1:0]          b_i,
   output logic                       s1_vld_o,
   output logic signed [2*DATA_W-1:0] prod_o,
   output logic                       prod_vld_o
);

   logic signed [DATA_W-1:0]   a_q;
   logic signed [DATA_W-1:0]   b_q;
   logic                       s1_vld_q;
   logic signed [2*DATA_W-1:0] prod_q;
   logic                       prod_vld_q;

   // S1 operand capture and S2 full-width signed product, valids ride alongside
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         a_q        <= '0;
         b_q        <= '0;
         s1_vld_q   <= 1'b0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
      end else begin
         s1_vld_q   <= in_vld_i;
         prod_vld_q <= s1_vld_q;
         if (in_vld_i) begin
            a_q <= a_i;
            b_q <= b_i;
         end
         if (s1_vld_q) begin
            prod_q <= a_q * b_q;
         end
      end
   end

   assign s1_vld_o   = s1_vld_q;
   assign prod_o     = prod_q;
   assign prod_vld_o = prod_vld_q;

endmodule

// File: rtl/macc_dot_engine.sv
// Signed dot product of vec_len+1 A/B pairs, clamped to a 32-bit result for C RAM.
// Latency: out_valid rises 4 cycles after the last pair is accepted.
// in_ready only in RUN; result held stable until out_ready takes it.
module macc_dot_engine
   import macc_dot_engine_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_L,
   macc_dot_engine_if.slave bus
);

   localparam int DATA_W = MACC_DATA_W;
   localparam int LEN_W  = MACC_LEN_W;
   localparam int ACC_W  = MACC_ACC_W;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

   state_t                     state_q;
   logic [LEN_W-1:0]           len_q;
   logic [LEN_W-1:0]           cnt_q;
   logic                       in_ready_q;
   logic                       out_valid_q;
   logic [DATA_W-1:0]          out_data_q;
   logic                       busy_q;
   logic                       sat_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_d;

   logic                       pair_acc;
   logic                       start_acc;
   logic                       s1_vld;
   logic signed [2*DATA_W-1:0] prod;
   logic                       prod_vld;
   logic                       pipe_empty;
   logic [DATA_W-1:0]          clamp_dat;
   logic                       clamp_hit;

   assign pair_acc   = bus.in_valid && in_ready_q;
   assign start_acc  = (state_q == ST_IDLE) && bus.start;
   assign pipe_empty = !s1_vld && !prod_vld;

   macc_dot_engine_mul_pipe #(
      .DATA_W (DATA_W)
   ) u_mul_pipe (
      .clk_i      (CLK),
      .rst_n_i    (RST_L),
      .in_vld_i   (pair_acc),
      .a_i        (bus.a_in),
      .b_i        (bus.b_in),
      .s1_vld_o   (s1_vld),
      .prod_o     (prod),
      .prod_vld_o (prod_vld)
   );

   // S3: accumulate sign-extended products; a fresh start wipes the sum
   always_comb begin
      acc_d = acc_q;
      if (start_acc) begin
         acc_d = '0;
      end else if (prod_vld) begin
         acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      end
   end

   // Accumulator register
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Clamp the settled accumulator into the signed result range
   always_comb begin
      clamp_dat = acc_q[DATA_W-1:0];
      clamp_hit = 1'b0;
      if (acc_q > ACC_MAX) begin
         clamp_dat = SAT_MAX;
         clamp_hit = 1'b1;
      end else if (acc_q < ACC_MIN) begin
         clamp_dat = SAT_MIN;
         clamp_hit = 1'b1;
      end
   end

   // Control FSM with registered handshake/status outputs
   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q    <= ST_RUN;
                  len_q      <= bus.vec_len;
                  cnt_q      <= '0;
                  sat_q      <= 1'b0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               if (pair_acc) begin
                  cnt_q <= cnt_q + 1'b1;
                  // Last pair: stop taking operands from the very next cycle
                  if (cnt_q == len_q) begin
                     state_q    <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // Both multiply stages idle means the final product is already in acc_q
               if (pipe_empty) begin
                  state_q     <= ST_OUT;
                  out_valid_q <= 1'b1;
                  out_data_q  <= clamp_dat;
                  sat_q       <= clamp_hit;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = busy_q;
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_macc_dot_engine.sv
// Self-checking bench for macc_dot_engine against an arithmetic reference model.
// Drives from #1 after each rising edge and samples there as well.
// Ends with a single summary line.
module tb_macc_dot_engine;

   logic CLK = 1'b0;
   logic RST_L;

   always #5 CLK = ~CLK;

   macc_dot_engine_if #(.DATA_W(32), .LEN_W(10)) bus ();

   macc_dot_engine dut (
      .CLK   (CLK),
      .RST_L (RST_L),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] av [0:1023];
   logic [31:0] bv [0:1023];

   // Reference: exact sum of products in wide arithmetic, then clamp. {sat, data}
   function automatic logic [32:0] model(input int len);
      logic signed [127:0] s;
      logic signed [127:0] pa;
      logic signed [127:0] pb;
      s = '0;
      for (int i = 0; i <= len; i++) begin
         pa = $signed(av[i]);
         pb = $signed(bv[i]);
         s  = s + pa * pb;
      end
      if (s > 128'sh7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
      if (s < -128'sh8000_0000) return {1'b1, 32'h8000_0000};
      return {1'b0, s[31:0]};
   endfunction

   function automatic logic [31:0] rnd_val(input bit big);
      int t;
      if (big) return $urandom;
      t = int'($urandom_range(2000)) - 1000;
      return t;
   endfunction

   // Runs one invocation: start, feed av/bv[0..len], wait for the result, stall, take.
   task automatic run_op(input int len, input bit gaps, input int stall, input bit noise,
                         output logic [31:0] res, output logic rsat, output int lat,
                         output bit stable, output bit rdy_low);
      int   idx;
      int   guard;
      logic iv;
      logic rdy;
      stable  = 1'b1;
      rdy_low = 1'b1;
      lat     = 999;
      res     = '0;
      rsat    = 1'b0;
      bus.vec_len = len[9:0];
      bus.start   = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
      idx   = 0;
      guard = 0;
      while (idx <= len && guard < 4000) begin
         iv = gaps ? guard[0] : 1'b1;
         bus.in_valid = iv;
         bus.a_in     = av[idx];
         bus.b_in     = bv[idx];
         rdy = bus.in_ready;
         if (noise && guard == 5) begin
            bus.start   = 1'b1;
            bus.vec_len = 10'd0;
         end
         @(posedge CLK); #1;
         bus.start = 1'b0;
         if (iv && rdy) idx++;
         guard++;
      end
      // Keep offering junk: it must be refused while draining
      bus.in_valid = 1'b1;
      bus.a_in     = 32'h1234_5678;
      bus.b_in     = 32'h7654_3210;
      if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.out_valid === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge CLK); #1;
      end
      bus.in_valid = 1'b0;
      if (lat != 999) begin
         res  = bus.out_data;
         rsat = bus.sat;
         for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            if (noise && s == 1) bus.start = 1'b1;
            @(posedge CLK); #1;
            bus.start = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.out_data !== res) stable = 1'b0;
         end
         bus.out_ready = 1'b1;
         if (noise) bus.start = 1'b1;
         @(posedge CLK); #1;
         bus.out_ready = 1'b0;
         bus.start     = 1'b0;
      end
   endtask

   task automatic test_reset;
      RST_L = 1'b0;
      bus.start = 1'b0; bus.vec_len = '0; bus.a_in = '0; bus.b_in = '0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.sat} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000", {bus.in_ready, bus.out_valid, bus.busy, bus.sat});
      end
      n_checks++;
      if (bus.out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 00000000", bus.out_data);
      end
      RST_L = 1'b1;
      @(posedge CLK); #1;
      // in_valid with no start must not wake the engine
      bus.in_valid = 1'b1;
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignores_valid: busy %b want 0", bus.busy);
      end
   endtask

   task automatic test_basic;
      logic [31:0] r; logic s; int lat; bit st; bit rl;
      for (int i = 0; i < 4; i++) begin
         av[i] = 2 * i + 1;
         bv[i] = 2 * i + 2;
      end
      run_op(3, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'd100) begin n_fail++; $display("FAIL basic_data: got %0d want 100", r); end
      n_checks++;
      if (s !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b want 0", s); end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
      n_checks++;
      if (rl !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_drop: in_ready still high after last accept"); end
   endtask

   task automatic test_len0;
      logic [31:0] r; logic s; int lat; bit st; bit rl;
      av[0] = -32'sd5;
      bv[0] = 32'd7;
      run_op(0, 1'b0, 2, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'hFFFF_FFDD) begin n_fail++; $display("FAIL len0_data: got %h want ffffffdd", r); end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL len0_latency: got %0d want 4", lat); end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_after_take: busy %b out_valid %b want 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_sat;
      logic [31:0] r; logic s; int lat; bit st; bit rl;
      av[0] = 32'h7FFF_FFFF; bv[0] = 32'h7FFF_FFFF;
      av[1] = 32'h7FFF_FFFF; bv[1] = 32'h7FFF_FFFF;
      run_op(1, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'h7FFF_FFFF || s !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_pos: got %h sat %b want 7fffffff sat 1", r, s);
      end
      n_checks++;
      if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b want 1", bus.sat); end
      av[0] = 32'd1; bv[0] = 32'd1;
      run_op(0, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'd1 || s !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clear: got %h sat %b want 00000001 sat 0", r, s);
      end
   endtask

   task automatic test_stall_gaps;
      logic [31:0] r; logic s; int lat; bit st; bit rl; logic [32:0] exp;
      for (int i = 0; i < 64; i++) begin
         av[i] = rnd_val(i[2]);
         bv[i] = rnd_val(1'b0);
      end
      exp = model(63);
      run_op(63, 1'b1, 5, 1'b1, r, s, lat, st, rl);
      n_checks++;
      if ({s, r} !== exp) begin n_fail++; $display("FAIL gaps_result: got %b/%h want %b/%h", s, r, exp[32], exp[31:0]); end
      n_checks++;
      if (st !== 1'b1) begin n_fail++; $display("FAIL stall_stable: out_data/out_valid moved while stalled"); end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL gaps_latency: got %0d want 4", lat); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_at_take_ignored: busy %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r; logic s; int lat; bit st; bit rl; bit seen;
      bus.vec_len = 10'd63;
      bus.start   = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.a_in = 32'd9; bus.b_in = 32'd9;
      repeat (10) @(posedge CLK);
      #1;
      RST_L = 1'b0;
      #1;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.sat, bus.out_data} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got rdy %b ov %b busy %b sat %b data %h want all 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.sat, bus.out_data);
      end
      bus.in_valid = 1'b0;
      #2 RST_L = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge CLK); #1;
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL reset_mid_quiet: engine active after reset, want idle"); end
      av[0] = 32'd2; bv[0] = 32'd3;
      av[1] = 32'd4; bv[1] = 32'd5;
      run_op(1, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'd26 || s !== 1'b0) begin n_fail++; $display("FAIL reset_fresh: got %0d sat %b want 26 sat 0", r, s); end
   endtask

   task automatic test_full_len;
      logic [31:0] r; logic s; int lat; bit st; bit rl;
      for (int i = 0; i < 1024; i++) begin
         av[i] = 32'h7FFF_FFFF;
         bv[i] = 32'h7FFF_FFFF;
      end
      run_op(1023, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'h7FFF_FFFF || s !== 1'b1) begin n_fail++; $display("FAIL full_pos: got %h sat %b want 7fffffff sat 1", r, s); end
      for (int i = 0; i < 1024; i++) av[i] = 32'h8000_0000;
      run_op(1023, 1'b0, 0, 1'b0, r, s, lat, st, rl);
      n_checks++;
      if (r !== 32'h8000_0000 || s !== 1'b1) begin n_fail++; $display("FAIL full_neg: got %h sat %b want 80000000 sat 1", r, s); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r; logic s; int lat; bit st; bit rl; logic [32:0] exp; int len; bit big;
      for (int t = 0; t < 12; t++) begin
         len = $urandom_range(15);
         big = ($urandom_range(2) == 0);
         for (int i = 0; i <= len; i++) begin
            av[i] = rnd_val(big);
            bv[i] = rnd_val(big);
         end
         exp = model(len);
         run_op(len, 1'($urandom_range(1)), $urandom_range(3), 1'($urandom_range(1)), r, s, lat, st, rl);
         n_checks++;
         if ({s, r} !== exp || lat != 4 || st !== 1'b1 || rl !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_%0d len %0d: got %b/%h lat %0d stable %b rdy_low %b want %b/%h lat 4 1 1",
                     t, len, s, r, lat, st, rl, exp[32], exp[31:0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_len0;
      test_sat;
      test_stall_gaps;
      test_reset_mid;
      test_full_len;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
